// File: rtl/chan_pkt_framer_if.sv
// AXI-Stream style channel used on both sides of the packet framer.
// The tuser width differs per side, so it is a parameter.
interface chan_pkt_framer_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 11
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/chan_pkt_framer.sv
// Frames bin-ordered channelizer samples into whole-frame packets with bin alignment,
// error resync, sequence numbers and EOB, presenting header fields on m_axis.tuser.
module chan_pkt_framer #(
    parameter int DATA_W = 32,
    parameter int CHAN_W = 11,
    parameter int LEN_W  = 16,
    parameter int SEQ_W  = 12,
    parameter int ERR_W  = 16
) (
    input  logic                ce_clk,
    input  logic                ce_rst_n,
    input  logic [CHAN_W:0]     cfg_frame_len,
    input  logic [7:0]          cfg_pkt_frames,
    input  logic                cfg_stb,
    input  logic                eob_req,
    input  logic                clear_seq,
    chan_pkt_framer_if.slave    s_axis,
    chan_pkt_framer_if.master   m_axis,
    output logic                cfg_err,
    output logic [ERR_W-1:0]    err_cnt
);
    typedef enum logic {ALIGN = 1'b0, RUN = 1'b1} state_t;

    localparam int BPB    = DATA_W / 8;
    localparam int PROD_W = CHAN_W + 1 + 8 + 16;
    localparam int USER_W = LEN_W + SEQ_W + 2;

    function automatic logic [PROD_W-1:0] pkt_bytes(input logic [CHAN_W:0] fl, input logic [7:0] pf);
        return PROD_W'(fl) * PROD_W'(pf) * PROD_W'(BPB);
    endfunction

    state_t              state_q, state_d;
    logic [CHAN_W-1:0]   bin_cnt_q, bin_cnt_d;
    logic [7:0]          frm_cnt_q, frm_cnt_d;
    logic [CHAN_W:0]     fl_q, fl_d, pend_fl_q, pend_fl_d;
    logic [7:0]          pf_q, pf_d, pend_pf_q, pend_pf_d;
    logic                pend_vld_q, pend_vld_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic                clr_pend_q, clr_pend_d;
    logic                eob_pend_q, eob_pend_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                rdy_en_q, rdy_en_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [USER_W-1:0]   m_user_q, m_user_d;

    logic                s_ready, in_acc;
    logic [CHAN_W:0]     cur_fl;
    logic [7:0]          cur_pf;
    logic [SEQ_W-1:0]    seq_cur;
    logic                at_boundary, bin_match, last_bin, last_frm, trunc, tlast;
    logic                unused_tlast;

    // Ready stays low until the first edge after reset release.
    assign s_ready       = rdy_en_q & (~m_valid_q | m_axis.tready);
    assign in_acc        = s_ready & s_axis.tvalid;
    assign s_axis.tready = s_ready;
    assign unused_tlast  = s_axis.tlast;

    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tuser  = m_user_q;
    assign err_cnt       = err_q;
    assign cfg_err       = (pkt_bytes(fl_q, pf_q) >> LEN_W) != '0;

    // NOTE: every _d gets a default at the top so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        bin_cnt_d  = bin_cnt_q;
        frm_cnt_d  = frm_cnt_q;
        fl_d       = fl_q;
        pf_d       = pf_q;
        pend_fl_d  = pend_fl_q;
        pend_pf_d  = pend_pf_q;
        pend_vld_d = pend_vld_q;
        err_d      = err_q;
        rdy_en_d   = 1'b1;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_data_d   = m_data_q;
        m_user_d   = m_user_q;
        trunc      = 1'b0;
        tlast      = 1'b0;
        cur_fl     = fl_q;
        cur_pf     = pf_q;

        // No packet is open in ALIGN, so pending config can take effect at once.
        if (state_q == ALIGN && pend_vld_q) begin
            cur_fl     = pend_fl_q;
            cur_pf     = pend_pf_q;
            fl_d       = pend_fl_q;
            pf_d       = pend_pf_q;
            pend_vld_d = 1'b0;
        end

        at_boundary = (state_q == ALIGN) || (bin_cnt_q == '0 && frm_cnt_q == '0);
        seq_cur     = (clr_pend_q && at_boundary) ? '0 : seq_q;
        seq_d       = seq_cur;
        clr_pend_d  = clear_seq | (clr_pend_q & ~at_boundary);
        eob_pend_d  = eob_pend_q | eob_req;

        bin_match = s_axis.tuser == bin_cnt_q;
        last_bin  = {1'b0, bin_cnt_q} == cur_fl - (CHAN_W+1)'(1);
        last_frm  = frm_cnt_q == cur_pf - 8'd1;

        if (m_axis.tready) m_valid_d = 1'b0;

        // In ALIGN the counters sit at zero, so bin_match means "this is bin 0".
        if (in_acc && (state_q == RUN || bin_match)) begin
            trunc     = ~bin_match;
            tlast     = trunc | (last_bin & last_frm);
            m_valid_d = 1'b1;
            m_data_d  = s_axis.tdata;
            m_last_d  = tlast;
            m_user_d  = {trunc, tlast & eob_pend_q, seq_cur, LEN_W'(pkt_bytes(cur_fl, cur_pf))};

            if (trunc) begin
                if (err_q != '1) err_d = err_q + ERR_W'(1);
                bin_cnt_d = '0;
                frm_cnt_d = '0;
                state_d   = ALIGN;
            end else begin
                state_d = RUN;
                if (last_bin) begin
                    bin_cnt_d = '0;
                    frm_cnt_d = last_frm ? 8'd0 : frm_cnt_q + 8'd1;
                end else begin
                    bin_cnt_d = bin_cnt_q + CHAN_W'(1);
                end
            end

            if (tlast) begin
                seq_d      = seq_cur + SEQ_W'(1);
                eob_pend_d = eob_req;
            end

            if (tlast && !trunc && state_q == RUN && pend_vld_q) begin
                fl_d       = pend_fl_q;
                pf_d       = pend_pf_q;
                pend_vld_d = 1'b0;
                if (pend_fl_q != fl_q) state_d = ALIGN;
            end
        end

        if (cfg_stb) begin
            pend_fl_d  = (cfg_frame_len == '0) ? (CHAN_W+1)'(1) : cfg_frame_len;
            pend_pf_d  = (cfg_pkt_frames == '0) ? 8'd1 : cfg_pkt_frames;
            pend_vld_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_q    <= ALIGN;
            bin_cnt_q  <= '0;
            frm_cnt_q  <= '0;
            fl_q       <= (CHAN_W+1)'(1);
            pf_q       <= 8'd1;
            pend_fl_q  <= (CHAN_W+1)'(1);
            pend_pf_q  <= 8'd1;
            pend_vld_q <= 1'b0;
            seq_q      <= '0;
            clr_pend_q <= 1'b0;
            eob_pend_q <= 1'b0;
            err_q      <= '0;
            rdy_en_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
            m_user_q   <= '0;
        end else begin
            state_q    <= state_d;
            bin_cnt_q  <= bin_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
            fl_q       <= fl_d;
            pf_q       <= pf_d;
            pend_fl_q  <= pend_fl_d;
            pend_pf_q  <= pend_pf_d;
            pend_vld_q <= pend_vld_d;
            seq_q      <= seq_d;
            clr_pend_q <= clr_pend_d;
            eob_pend_q <= eob_pend_d;
            err_q      <= err_d;
            rdy_en_q   <= rdy_en_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_data_q   <= m_data_d;
            m_user_q   <= m_user_d;
        end
    end
endmodule

// File: tb/tb_chan_pkt_framer.sv
// Scoreboard bench for chan_pkt_framer: directed bin streams push expected beats,
// a monitor pops and compares every beat the framer hands off.
module tb_chan_pkt_framer;
    localparam int DATA_W = 32;
    localparam int CHAN_W = 11;
    localparam int LEN_W  = 16;
    localparam int SEQ_W  = 12;
    localparam int ERR_W  = 16;
    localparam int USER_W = LEN_W + SEQ_W + 2;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                last;
        bit                trunc;
        bit                eob;
        logic [SEQ_W-1:0]  seq;
        logic [LEN_W-1:0]  len;
    } exp_t;

    logic              ce_clk = 1'b0;
    logic              ce_rst_n = 1'b1;
    logic [CHAN_W:0]   cfg_frame_len = '0;
    logic [7:0]        cfg_pkt_frames = '0;
    logic              cfg_stb = 1'b0;
    logic              eob_req = 1'b0;
    logic              clear_seq = 1'b0;
    logic              cfg_err;
    logic [ERR_W-1:0]  err_cnt;

    chan_pkt_framer_if #(.DATA_W(DATA_W), .USER_W(CHAN_W)) s_if();
    chan_pkt_framer_if #(.DATA_W(DATA_W), .USER_W(USER_W)) m_if();

    chan_pkt_framer #(
        .DATA_W(DATA_W), .CHAN_W(CHAN_W), .LEN_W(LEN_W), .SEQ_W(SEQ_W), .ERR_W(ERR_W)
    ) dut (
        .ce_clk        (ce_clk),
        .ce_rst_n      (ce_rst_n),
        .cfg_frame_len (cfg_frame_len),
        .cfg_pkt_frames(cfg_pkt_frames),
        .cfg_stb       (cfg_stb),
        .eob_req       (eob_req),
        .clear_seq     (clear_seq),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .cfg_err       (cfg_err),
        .err_cnt       (err_cnt)
    );

    always #5 ce_clk = ~ce_clk;

    exp_t        sb_q[$];
    int          checks = 0;
    int          fails = 0;
    int          cur_seq = 0;
    int          exp_len = 0;
    logic [31:0] sn = 32'h1000;
    logic [31:0] last_data = '0;
    bit          rnd = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge ce_clk);
        #1;
    endtask

    task automatic cfg(input int fl, input int pf);
        cfg_frame_len  = (CHAN_W+1)'(fl);
        cfg_pkt_frames = 8'(pf);
        cfg_stb        = 1'b1;
        @(posedge ce_clk); #1;
        cfg_stb        = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_seq = 1'b1;
        @(posedge ce_clk); #1;
        clear_seq = 1'b0;
    endtask

    // Offers one sample; if emit, the expected output beat is queued as it is accepted.
    task automatic send(input int bin, input bit emit, input bit last, input bit trunc,
                        input bit eob, input bit eob_pulse);
        bit   acc;
        int   n;
        exp_t e;
        acc = 1'b0;
        n   = 0;
        s_if.tdata  = sn;
        last_data   = sn;
        sn          = sn + 32'd1;
        s_if.tuser  = CHAN_W'(bin);
        s_if.tvalid = 1'b1;
        eob_req     = eob_pulse;
        while (!acc && n < 1000) begin
            @(negedge ce_clk);
            acc = s_if.tready;
            if (acc && emit) begin
                e.data  = s_if.tdata;
                e.last  = last;
                e.trunc = trunc;
                e.eob   = eob;
                e.seq   = SEQ_W'(cur_seq);
                e.len   = LEN_W'(exp_len);
                sb_q.push_back(e);
            end
            @(posedge ce_clk); #1;
            eob_req = 1'b0;
            n++;
        end
        s_if.tvalid = 1'b0;
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: bin %0d not accepted, required acceptance within 1000 cycles", bin);
        end
    endtask

    task automatic send_pkt(input int fl, input int pf, input int eob_at);
        for (int b = 0; b < fl * pf; b++)
            send(b % fl, 1'b1, b == fl * pf - 1, 1'b0, (b == fl * pf - 1) && (eob_at >= 0), b == eob_at);
        cur_seq++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge ce_clk);
            n++;
        end
        #1;
        check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin : ready_gen
        m_if.tready = 1'b1;
        forever begin
            @(posedge ce_clk); #1;
            m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge ce_clk);
            if (ce_rst_n && m_if.tvalid && m_if.tready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got data=%0h tuser=%0h, required no beat", m_if.tdata, m_if.tuser);
                end else begin
                    e = sb_q.pop_front();
                    if (m_if.tdata !== e.data || m_if.tlast !== e.last ||
                        m_if.tuser[USER_W-1] !== e.trunc ||
                        m_if.tuser[LEN_W+SEQ_W-1:LEN_W] !== e.seq ||
                        m_if.tuser[LEN_W-1:0] !== e.len ||
                        (e.last && m_if.tuser[USER_W-2] !== e.eob)) begin
                        fails++;
                        $display("FAIL beat: got data=%0h last=%0b trunc=%0b eob=%0b seq=%0d len=%0d, required data=%0h last=%0b trunc=%0b eob=%0b seq=%0d len=%0d",
                                 m_if.tdata, m_if.tlast, m_if.tuser[USER_W-1], m_if.tuser[USER_W-2],
                                 m_if.tuser[LEN_W+SEQ_W-1:LEN_W], m_if.tuser[LEN_W-1:0],
                                 e.data, e.last, e.trunc, e.eob, e.seq, e.len);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;

        // Reset state
        #1 ce_rst_n = 1'b0;
        #1;
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        @(posedge ce_clk);
        @(posedge ce_clk);
        @(negedge ce_clk) ce_rst_n = 1'b1;
        wait_cyc(1);

        // Test 1: 4 bins x 2 frames, full rate, 1-cycle latency
        exp_len = 32;
        cfg(4, 2);
        send(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("latency_tvalid", 64'(m_if.tvalid), 64'd1);
        check("latency_tdata", 64'(m_if.tdata), 64'(last_data));
        for (int b = 1; b < 8; b++) send(b % 4, 1'b1, b == 7, 1'b0, 1'b0, 1'b0);
        cur_seq++;
        send_pkt(4, 2, -1);
        send_pkt(4, 2, -1);

        // Test 3: bin 3 after bin 1 truncates packet 3, resync on bin 0
        send(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cur_seq++;
        send(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt(4, 2, -1);
        wait_cyc(1);
        check("err_cnt_after_trunc", 64'(err_cnt), 64'd1);

        // Test 4: EOB on packet 5 only, then clear_seq restarts at 0
        send_pkt(4, 2, 3);
        send_pkt(4, 2, -1);
        pulse_clear();
        cur_seq = 0;
        send_pkt(4, 2, -1);

        // Test 5: random backpressure, frame_len 4->2 mid-packet applies after tlast
        rnd = 1'b1;
        send(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cfg(2, 2);
        for (int b = 2; b < 8; b++) send(b % 4, 1'b1, b == 7, 1'b0, 1'b0, 1'b0);
        cur_seq++;
        exp_len = 16;
        send_pkt(2, 2, -1);
        send_pkt(2, 2, -1);
        rnd = 1'b0;
        drain();

        // Test 6: asynchronous reset mid-packet
        send(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 ce_rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("async_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("async_rst_s_tready", 64'(s_if.tready), 64'd0);
        check("async_rst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge ce_clk);
        @(posedge ce_clk);
        @(negedge ce_clk) ce_rst_n = 1'b1;
        wait_cyc(2);
        cur_seq = 0;

        // cfg_err boundary: 2048*8*4 = 65536 flags, 2048*7*4 = 57344 does not
        cfg(2048, 8);
        wait_cyc(2);
        check("cfg_err_at_limit", 64'(cfg_err), 64'd1);
        cfg(2048, 7);
        wait_cyc(2);
        check("cfg_err_below_limit", 64'(cfg_err), 64'd0);

        // frame_len 0 behaves as 1; ALIGN drops non-zero bins
        exp_len = 12;
        cfg(0, 3);
        send(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt(1, 3, -1);
        cfg(4, 2);
        send_pkt(1, 3, -1);
        exp_len = 32;
        send(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt(4, 2, -1);
        drain();
        check("err_cnt_after_realign", 64'(err_cnt), 64'd0);

        wait_cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
